// File: rtl/fp_mul.sv
// fp_mul: single-cycle IEEE-754 binary32 multiplier with a registered result.
// Subnormal inputs and outputs are flushed to signed zero; NaN results are canonical 0x7FC00000.
// Optional macro FP_MUL_ROUND_EN: round to nearest, ties to even. Default build truncates.
module fp_mul (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // Operand fields
   logic        sa, sb, sr;
   logic [7:0]  ea, eb;
   logic [22:0] fa, fb;

   assign sa = a[31];
   assign sb = b[31];
   assign ea = a[30:23];
   assign eb = b[30:23];
   assign fa = a[22:0];
   assign fb = b[22:0];
   assign sr = sa ^ sb;

   // Operand classes; exponent 0 covers both true zero and flushed subnormals
   logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

   assign a_zero = (ea == 8'd0);
   assign b_zero = (eb == 8'd0);
   assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
   assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
   assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
   assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);

   // Significand product and single-step normalisation
   logic [47:0] prod;
   logic [46:0] nprod;
   logic [22:0] sig;
   logic [9:0]  exp_pre;

   assign prod    = {1'b1, fa} * {1'b1, fb};
   // Shift so the leading one is dropped and bit 46 is the first fraction bit
   assign nprod   = prod[47] ? prod[46:0] : {prod[45:0], 1'b0};
   assign sig     = nprod[46:24];
   // Two's-complement 10-bit exponent; range -125..384 fits
   assign exp_pre = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]} - 10'd127;

   logic [23:0] sig_r;

`ifdef FP_MUL_ROUND_EN
   logic guard, rbit, sticky, rnd_up;

   assign guard  = nprod[23];
   assign rbit   = nprod[22];
   assign sticky = |nprod[21:0];
   // Round up above half, or on an exact half when the kept LSB is odd
   assign rnd_up = guard & (rbit | sticky | sig[0]);
   assign sig_r  = {1'b0, sig} + {23'd0, rnd_up};
`else
   logic unused_discard;

   assign unused_discard = ^nprod[23:0];
   assign sig_r          = {1'b0, sig};
`endif

   // Carry out of rounding leaves the fraction all-zero and bumps the exponent
   logic [9:0] exp_fin;

   assign exp_fin = exp_pre + {9'd0, sig_r[23]};

   // Next result: specials first, then range checks on the finite product
   logic [31:0] result_d;

   always_comb begin
      result_d = {sr, exp_fin[7:0], sig_r[22:0]};
      if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
         result_d = QNAN;
      end else if (a_inf || b_inf) begin
         result_d = {sr, 8'hFF, 23'd0};
      end else if (a_zero || b_zero) begin
         result_d = {sr, 31'd0};
      end else if ($signed(exp_fin) <= $signed(10'sd0)) begin
         result_d = {sr, 31'd0};
      end else if ($signed(exp_fin) >= $signed(10'sd255)) begin
         result_d = {sr, 8'hFF, 23'd0};
      end
   end

   // Result register, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result <= 32'h0000_0000;
      end else begin
         result <= result_d;
      end
   end

endmodule

// File: tb/tb_fp_mul.sv
// Directed-vector bench for fp_mul; expectations follow the FP_MUL_ROUND_EN setting.
module tb_fp_mul;

   logic        clk;
   logic        rst_n;
   logic [31:0] a, b;
   logic [31:0] result;

   int n_applied = 0;
   int n_err     = 0;

   fp_mul dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      string       name;
   } vec_t;

`ifdef FP_MUL_ROUND_EN
   localparam logic [31:0] TIE_EXP   = 32'h3FC0_0002;
   localparam logic [31:0] CARRY_EXP = 32'h4000_0000;
   localparam logic [31:0] COVF_EXP  = 32'h7F80_0000;
`else
   localparam logic [31:0] TIE_EXP   = 32'h3FC0_0001;
   localparam logic [31:0] CARRY_EXP = 32'h3FFF_FFFF;
   localparam logic [31:0] COVF_EXP  = 32'h7F7F_FFFF;
`endif

   localparam int NV = 20;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_applied++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %08h, expected %08h", name, got, want);
      end
   endtask

   initial begin
      vecs[0]  = '{32'h411C0000, 32'h3F100000, 32'h40AF8000, "9.75x0.5625"};
      vecs[1]  = '{32'h45FA0000, 32'hC5FA0000, 32'hCC742400, "8000x-8000"};
      vecs[2]  = '{32'h00000032, 32'h0000003C, 32'h00000000, "subnorm_x_subnorm"};
      vecs[3]  = '{32'h3F800001, 32'h3FC00000, TIE_EXP,      "tie"};
      vecs[4]  = '{32'h7F000000, 32'h40000000, 32'h7F800000, "overflow"};
      vecs[5]  = '{32'h7F800000, 32'h00000000, 32'h7FC00000, "inf_x_zero"};
      vecs[6]  = '{32'h00800000, 32'h00800000, 32'h00000000, "underflow"};
      vecs[7]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, "1x1"};
      vecs[8]  = '{32'h40000000, 32'h40400000, 32'h40C00000, "2x3"};
      vecs[9]  = '{32'hBFC00000, 32'h40000000, 32'hC0400000, "-1.5x2"};
      vecs[10] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, "nan_in"};
      vecs[11] = '{32'h7F800000, 32'hC0000000, 32'hFF800000, "inf_x_neg"};
      vecs[12] = '{32'h80000000, 32'h40A00000, 32'h80000000, "negzero_x_5"};
      vecs[13] = '{32'h00000001, 32'h7F800000, 32'h7FC00000, "subnorm_x_inf"};
      vecs[14] = '{32'hFF800000, 32'hFF800000, 32'h7F800000, "ninf_x_ninf"};
      vecs[15] = '{32'h3F842108, 32'h3FF80000, CARRY_EXP,    "round_carry"};
      vecs[16] = '{32'h7F042108, 32'h3FF80000, COVF_EXP,     "round_carry_ovf"};
      vecs[17] = '{32'h00800000, 32'h3F000000, 32'h00000000, "exp_zero_flush"};
      vecs[18] = '{32'h80800000, 32'h3F000000, 32'h80000000, "neg_flush"};
      vecs[19] = '{32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, "max_sig_sq"};

      rst_n = 1'b0;
      a     = 32'h3F800000;
      b     = 32'h3F800000;
      #1;
      check("reset_async", result, 32'h0);
      repeat (2) @(negedge clk);
      check("reset_held", result, 32'h0);
      rst_n = 1'b1;

      // Isolated vectors: one operand pair per edge, checked after that edge
      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         a = vecs[i].a;
         b = vecs[i].b;
         @(posedge clk);
         #1;
         check(vecs[i].name, result, vecs[i].exp);
      end

      // Streaming: new operands every edge, each result from the previous pair
      @(negedge clk);
      a = vecs[0].a;
      b = vecs[0].b;
      for (int i = 1; i < NV; i++) begin
         @(negedge clk);
         check({"stream_", vecs[i-1].name}, result, vecs[i-1].exp);
         a = vecs[i].a;
         b = vecs[i].b;
      end
      @(negedge clk);
      check({"stream_", vecs[NV-1].name}, result, vecs[NV-1].exp);

      // Reset mid-stream: clears at once, holds through an edge, resumes cleanly
      a = vecs[8].a;
      b = vecs[8].b;
      @(posedge clk);
      #2;
      check("pre_reset", result, vecs[8].exp);
      a = vecs[1].a;
      b = vecs[1].b;
      rst_n = 1'b0;
      #1;
      check("midstream_reset", result, 32'h0);
      @(posedge clk);
      #1;
      check("reset_over_edge", result, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_after_reset", result, vecs[1].exp);
      @(negedge clk);
      a = vecs[0].a;
      b = vecs[0].b;
      @(posedge clk);
      #1;
      check("second_after_reset", result, vecs[0].exp);

      $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_err);
      $finish;
   end

endmodule
